// File: rtl/gcd_engine_if.sv
// Handshake and data bundle for gcd_engine: a requester drives start and
// the operands, the engine returns status, result and iteration count.
interface gcd_engine_if #(
    parameter int WIDTH  = 16,
    parameter int ITER_W = 16
);
    logic              start;
    logic [WIDTH-1:0]  a_in;
    logic [WIDTH-1:0]  b_in;
    logic              busy;
    logic              done;
    logic [WIDTH-1:0]  gcd_out;
    logic [ITER_W-1:0] iter_count;
    logic              err;

    // Requester side
    modport master (
        output start, a_in, b_in,
        input  busy, done, gcd_out, iter_count, err
    );

    // Engine side
    modport slave (
        input  start, a_in, b_in,
        output busy, done, gcd_out, iter_count, err
    );
endinterface

// File: rtl/gcd_engine.sv
// gcd_engine: repeated-subtraction GCD with a start/busy/done handshake.
// Operands load in one cycle, each CALC cycle does one subtraction or the
// terminating decision, and results are held until the next accepted start.
module gcd_engine #(
    parameter int WIDTH  = 16,
    parameter int ITER_W = 16
) (
    input  logic        clk,
    input  logic        rst,
    gcd_engine_if.slave bus
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [WIDTH-1:0]  r_a;
    logic [WIDTH-1:0]  r_b;
    logic [WIDTH-1:0]  r_gcd;
    logic [ITER_W-1:0] r_iter;
    logic              r_err;

    logic              w_a_zero;
    logic              w_b_zero;
    logic              w_equal;
    logic              w_a_lt_b;
    logic              w_finish;

    // Counter stops at all-ones instead of wrapping; the operation still completes.
    function automatic logic [ITER_W-1:0] sat_inc(input logic [ITER_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    assign w_a_zero = (r_a == '0);
    assign w_b_zero = (r_b == '0);
    assign w_equal  = (r_a == r_b);
    assign w_a_lt_b = (r_a < r_b);
    // Any zero operand or equality ends the reduction this cycle.
    assign w_finish = w_a_zero || w_b_zero || w_equal;

    // State register; reset overrides every transition, including mid-CALC.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode; start is only honoured in IDLE.
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_state_nxt = S_CALC;
                end
            end
            S_CALC: begin
                if (w_finish) begin
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // Datapath: operand load, one subtraction per cycle, result capture.
    // The larger operand is always the one reduced, so no underflow occurs.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_a    <= '0;
            r_b    <= '0;
            r_gcd  <= '0;
            r_iter <= '0;
            r_err  <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_a    <= bus.a_in;
                        r_b    <= bus.b_in;
                        r_gcd  <= '0;
                        r_iter <= '0;
                        r_err  <= 1'b0;
                    end
                end
                S_CALC: begin
                    if (w_a_zero && w_b_zero) begin
                        r_gcd <= '0;
                        r_err <= 1'b1;
                    end else if (w_a_zero) begin
                        r_gcd <= r_b;
                    end else if (w_b_zero) begin
                        r_gcd <= r_a;
                    end else if (w_equal) begin
                        r_gcd <= r_a;
                    end else if (w_a_lt_b) begin
                        r_b    <= r_b - r_a;
                        r_iter <= sat_inc(r_iter);
                    end else begin
                        r_a    <= r_a - r_b;
                        r_iter <= sat_inc(r_iter);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Status decodes straight from the state register; data outputs are registered.
    assign bus.busy       = (r_state == S_CALC);
    assign bus.done       = (r_state == S_DONE);
    assign bus.gcd_out    = r_gcd;
    assign bus.iter_count = r_iter;
    assign bus.err        = r_err;

endmodule

// File: tb/tb_gcd_engine.sv
// Self-checking bench for gcd_engine: table-driven vectors on a 16-bit
// instance plus directed handshake, reset and saturation sequences on
// 8-bit instances with 8-bit and 4-bit iteration counters.
module tb_gcd_engine;

    logic clk;
    logic rst;

    int n_checks;
    int n_err;

    gcd_engine_if #(.WIDTH(16), .ITER_W(16)) bus16 ();
    gcd_engine_if #(.WIDTH(8),  .ITER_W(8))  bus8a ();
    gcd_engine_if #(.WIDTH(8),  .ITER_W(4))  bus8b ();

    gcd_engine #(.WIDTH(16), .ITER_W(16)) u_dut16 (.clk(clk), .rst(rst), .bus(bus16));
    gcd_engine #(.WIDTH(8),  .ITER_W(8))  u_dut8a (.clk(clk), .rst(rst), .bus(bus8a));
    gcd_engine #(.WIDTH(8),  .ITER_W(4))  u_dut8b (.clk(clk), .rst(rst), .bus(bus8b));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic [15:0] g;
        int          it;
        logic        e;
        int          dc;
    } vec_t;

    vec_t vecs [9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Pulse start for one cycle, then follow the 16-bit engine to its done cycle.
    // Returns the cycle number of done (-1 on timeout) and a count of cycles where
    // busy disagreed with the expected busy-until-done pattern.
    task automatic run16(input logic [15:0] a, input logic [15:0] b,
                         output int dcyc, output int busy_bad);
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.a_in  = a;
        bus16.b_in  = b;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        bus16.a_in  = 16'hBEEF;
        bus16.b_in  = 16'h1234;
        dcyc     = -1;
        busy_bad = 0;
        for (int c = 1; c <= 200; c++) begin
            if (bus16.done) begin
                dcyc = c;
                if (bus16.busy) busy_bad++;
                break;
            end
            if (!bus16.busy) busy_bad++;
            @(posedge clk);
            #1;
        end
    endtask

    initial begin
        int dcyc;
        int bbad;
        int d8a;
        int d8b;
        logic [15:0] held;

        n_checks = 0;
        n_err    = 0;

        vecs[0] = '{16'd48,  16'd18, 16'd6,  4, 1'b0, 6};
        vecs[1] = '{16'd12,  16'd18, 16'd6,  2, 1'b0, 4};
        vecs[2] = '{16'd0,   16'd35, 16'd35, 0, 1'b0, 2};
        vecs[3] = '{16'd35,  16'd0,  16'd35, 0, 1'b0, 2};
        vecs[4] = '{16'd9,   16'd9,  16'd9,  0, 1'b0, 2};
        vecs[5] = '{16'd0,   16'd0,  16'd0,  0, 1'b1, 2};
        vecs[6] = '{16'd21,  16'd14, 16'd7,  2, 1'b0, 4};
        vecs[7] = '{16'd100, 16'd75, 16'd25, 3, 1'b0, 5};
        vecs[8] = '{16'd17,  16'd5,  16'd1,  6, 1'b0, 8};

        // Reset held two cycles with start asserted: nothing may be accepted.
        rst = 1'b1;
        bus16.start = 1'b1; bus16.a_in = 16'd5; bus16.b_in = 16'd7;
        bus8a.start = 1'b1; bus8a.a_in = 8'd5;  bus8a.b_in = 8'd7;
        bus8b.start = 1'b1; bus8b.a_in = 8'd5;  bus8b.b_in = 8'd7;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy",  bus16.busy,       0);
        chk("rst_done",  bus16.done,       0);
        chk("rst_gcd",   bus16.gcd_out,    0);
        chk("rst_iter",  bus16.iter_count, 0);
        chk("rst_err",   bus16.err,        0);
        chk("rst8_busy", bus8a.busy | bus8b.busy, 0);
        bus16.start = 1'b0;
        bus8a.start = 1'b0;
        bus8b.start = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            chk("idle_busy", bus16.busy, 0);
            chk("idle_done", bus16.done, 0);
        end

        // Table-driven operations on the 16-bit engine.
        for (int i = 0; i < 9; i++) begin
            run16(vecs[i].a, vecs[i].b, dcyc, bbad);
            chk("vec_done_cycle", dcyc,             vecs[i].dc);
            chk("vec_busy_shape", bbad,             0);
            chk("vec_gcd",        bus16.gcd_out,    vecs[i].g);
            chk("vec_iter",       bus16.iter_count, vecs[i].it);
            chk("vec_err",        bus16.err,        vecs[i].e);
            @(posedge clk);
            #1;
            chk("vec_done_pulse", bus16.done,       0);
            chk("vec_gcd_held",   bus16.gcd_out,    vecs[i].g);
            chk("vec_err_held",   bus16.err,        vecs[i].e);
        end

        // start held high with operands churning during CALC: result must be
        // unaffected and the next operation starts only from IDLE after done.
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.a_in  = 16'd48;
        bus16.b_in  = 16'd18;
        @(posedge clk);
        #1;
        dcyc = -1;
        for (int c = 1; c <= 50; c++) begin
            if (bus16.done) begin
                dcyc = c;
                break;
            end
            bus16.a_in = 16'(c * 37 + 3);
            bus16.b_in = 16'(c * 11 + 1);
            @(posedge clk);
            #1;
        end
        chk("hold_done_cycle", dcyc,             6);
        chk("hold_gcd",        bus16.gcd_out,    6);
        chk("hold_iter",       bus16.iter_count, 4);
        bus16.a_in = 16'd21;
        bus16.b_in = 16'd14;
        @(posedge clk);
        #1;
        chk("hold_idle_busy",  bus16.busy,       0);
        chk("hold_idle_gcd",   bus16.gcd_out,    6);
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        chk("hold_restart_busy", bus16.busy, 1);
        dcyc = -1;
        for (int c = 1; c <= 50; c++) begin
            if (bus16.done) begin
                dcyc = c;
                break;
            end
            @(posedge clk);
            #1;
        end
        chk("hold2_done_cycle", dcyc,             4);
        chk("hold2_gcd",        bus16.gcd_out,    7);
        chk("hold2_iter",       bus16.iter_count, 2);
        @(posedge clk);
        #1;

        // start pulsed only during the DONE cycle must be dropped.
        run16(16'd9, 16'd9, dcyc, bbad);
        chk("donepulse_cycle", dcyc, 2);
        bus16.start = 1'b1;
        bus16.a_in  = 16'd21;
        bus16.b_in  = 16'd14;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        chk("donepulse_busy0", bus16.busy,    0);
        @(posedge clk);
        #1;
        chk("donepulse_busy1", bus16.busy,    0);
        chk("donepulse_gcd",   bus16.gcd_out, 9);

        // Reset in the third CALC cycle of (48,18), then a fresh (21,14).
        @(negedge clk);
        bus16.start = 1'b1;
        bus16.a_in  = 16'd48;
        bus16.b_in  = 16'd18;
        @(posedge clk);
        #1;
        bus16.start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("mid_busy_c3", bus16.busy,       1);
        chk("mid_iter_c3", bus16.iter_count, 2);
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        chk("mid_rst_busy", bus16.busy,       0);
        chk("mid_rst_done", bus16.done,       0);
        chk("mid_rst_gcd",  bus16.gcd_out,    0);
        chk("mid_rst_iter", bus16.iter_count, 0);
        chk("mid_rst_err",  bus16.err,        0);
        @(posedge clk);
        #1;
        chk("mid_rst_stay_idle", bus16.busy, 0);
        run16(16'd21, 16'd14, dcyc, bbad);
        chk("post_rst_cycle", dcyc,             4);
        chk("post_rst_gcd",   bus16.gcd_out,    7);
        chk("post_rst_iter",  bus16.iter_count, 2);

        // Worst case on the 8-bit engines: (1,255) needs 254 subtractions;
        // the 4-bit counter saturates at 15.
        @(negedge clk);
        bus8a.start = 1'b1; bus8a.a_in = 8'd1; bus8a.b_in = 8'd255;
        bus8b.start = 1'b1; bus8b.a_in = 8'd1; bus8b.b_in = 8'd255;
        @(posedge clk);
        #1;
        bus8a.start = 1'b0;
        bus8b.start = 1'b0;
        d8a = -1;
        d8b = -1;
        for (int c = 1; c <= 400; c++) begin
            if (bus8a.done && d8a < 0) d8a = c;
            if (bus8b.done && d8b < 0) d8b = c;
            if (c == 20) chk("w8b_iter_sat_busy", bus8b.iter_count, 15);
            if (d8a >= 0 && d8b >= 0) break;
            @(posedge clk);
            #1;
        end
        chk("w8a_done_cycle", d8a,              256);
        chk("w8b_done_cycle", d8b,              256);
        chk("w8a_gcd",        bus8a.gcd_out,    1);
        chk("w8a_iter",       bus8a.iter_count, 254);
        chk("w8b_gcd",        bus8b.gcd_out,    1);
        chk("w8b_iter",       bus8b.iter_count, 15);
        chk("w8_err",         bus8a.err | bus8b.err, 0);
        held = {8'd0, bus8a.gcd_out};
        repeat (3) @(posedge clk);
        #1;
        chk("w8a_gcd_held",   bus8a.gcd_out, held);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end

endmodule
